// File: rtl/spike_cnt_binner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_cnt_binner_pkg
// Description : Shared constants and helpers for the spike count binner.
//               Holds the default pool size and count width, the popcount
//               width function and the saturation ceiling constant.
// Config      : SPIKE_CNT_SAT_EN selects saturating vs. wrapping counts
//               (consumed by spike_cnt_binner).
// Revision    : 1.0 - initial release
// ============================================================================
package spike_cnt_binner_pkg;

  // Default pool size and count width (32-bit int input of the muscle model).
  localparam int NEURONS_DEF = 128;
  localparam int CNT_W_DEF   = 32;

  // Saturation ceiling for the default 32-bit count: the largest positive
  // signed value, so the downstream int_to_float never sees a negative.
  localparam logic [CNT_W_DEF-1:0] SAT_CEIL_DEF = 32'h7FFF_FFFF;

  // Width needed to hold a popcount of n bits: values 0..n inclusive.
  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : spike_cnt_binner_pkg
`default_nettype wire

// File: rtl/spike_cnt_binner_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_cnt_binner_if
// Description : Spike input / count output bundle of the spike count binner.
// Ports       : i_spike_vec [NEURONS] - one spike bit per motoneuron
//               i_en                  - count enable
//               i_step                - window-close strobe
//               o_spike_cnt [CNT_W]   - count of the last closed window
//               o_cnt_valid           - one-cycle pulse on count update
//               o_ovf                 - last closed window overflowed
// Modports    : master drives spikes/strobe, slave (the binner) drives counts.
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_cnt_binner_if
  import spike_cnt_binner_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  logic [NEURONS-1:0] i_spike_vec;
  logic               i_en;
  logic               i_step;
  logic [CNT_W-1:0]   o_spike_cnt;
  logic               o_cnt_valid;
  logic               o_ovf;

  modport master (
    output i_spike_vec,
    output i_en,
    output i_step,
    input  o_spike_cnt,
    input  o_cnt_valid,
    input  o_ovf
  );

  modport slave (
    input  i_spike_vec,
    input  i_en,
    input  i_step,
    output o_spike_cnt,
    output o_cnt_valid,
    output o_ovf
  );

endinterface : spike_cnt_binner_if
`default_nettype wire

// File: rtl/spike_cnt_binner_popcount.sv
`default_nettype none
// ============================================================================
// Module      : spike_popcount
// Description : Combinational binary adder tree counting the ones in a spike
//               vector. The vector is padded with zeros up to a power of two
//               so every tree level halves cleanly.
// Ports       : spike_vec [NEURONS] - input bits
//               cnt [PC_W]          - number of ones in spike_vec
// Revision    : 1.0 - initial release
// ============================================================================
module spike_popcount
  import spike_cnt_binner_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int PC_W    = pc_width(NEURONS)
) (
  input  wire logic [NEURONS-1:0] spike_vec,
  output logic      [PC_W-1:0]    cnt
);

  localparam int LEVELS = (NEURONS > 1) ? $clog2(NEURONS) : 0;
  localparam int LEAVES = 1 << LEVELS;

  // Level 0 holds the (padded) leaves; level l holds LEAVES>>l partial sums.
  // Partial sums never exceed NEURONS, so PC_W bits suffice at every level.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NODES = LEAVES >> l;
    logic [PC_W-1:0] sum [NODES];

    for (genvar j = 0; j < NODES; j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < NEURONS) begin : g_bit
          assign sum[j] = PC_W'(spike_vec[j]);
        end else begin : g_pad
          assign sum[j] = '0;
        end
      end else begin : g_add
        assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
      end
    end
  end

  assign cnt = g_lvl[LEVELS].sum[0];

endmodule : spike_popcount
`default_nettype wire

// File: rtl/spike_cnt_binner.sv
`default_nettype none
// ============================================================================
// Module      : spike_cnt_binner
// Description : Counts motoneuron spikes over one simulation step and presents
//               the per-step total to the muscle model. Two stages:
//                 1) registered popcount of the gated spike vector + strobe
//                 2) window accumulator; a delayed strobe closes the window,
//                    publishes acc + current popcount and restarts from 0.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - spike_cnt_binner_if.slave (spikes in, counts out)
// Config      : SPIKE_CNT_SAT_EN defined   -> counts saturate at
//                                             2^(CNT_W-1)-1, o_ovf = clamped
//               SPIKE_CNT_SAT_EN undefined -> counts wrap modulo 2^CNT_W,
//                                             o_ovf = carry out
// Revision    : 1.0 - initial release
// ============================================================================
module spike_cnt_binner
  import spike_cnt_binner_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              reset,
  spike_cnt_binner_if.slave      bus
);

  localparam int PC_W = pc_width(NEURONS);

  // --------------------------------------------------------------------------
  // Stage 1: popcount, gated by the enable, registered with the strobe
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] r_pc;
  logic            r_step;

  spike_popcount #(
    .NEURONS (NEURONS),
    .PC_W    (PC_W)
  ) u_popcount (
    .spike_vec (bus.i_spike_vec),
    .cnt       (w_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= '0;
      r_step <= 1'b0;
    end else begin
      r_pc   <= bus.i_en ? w_pc : '0;
      r_step <= bus.i_step;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: accumulate; the add is one bit wider to expose the carry
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_acc;
  logic             r_ovf_acc;
  logic [CNT_W-1:0] r_spike_cnt;
  logic             r_cnt_valid;
  logic             r_ovf;

  logic [CNT_W-1:0] w_pc_ext;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_next;
  logic             w_over;

  assign w_pc_ext = CNT_W'(r_pc);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_pc_ext};

`ifdef SPIKE_CNT_SAT_EN
  // Largest positive signed value of CNT_W bits.
  localparam logic [CNT_W-1:0] SAT_CEIL = {1'b0, {(CNT_W-1){1'b1}}};

  // The accumulator never exceeds SAT_CEIL, so the wide sum cannot wrap and
  // a plain compare detects every clamp.
  assign w_over = (w_sum > {1'b0, SAT_CEIL});
  assign w_next = w_over ? SAT_CEIL : w_sum[CNT_W-1:0];
`else
  assign w_over = w_sum[CNT_W];
  assign w_next = w_sum[CNT_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
      r_spike_cnt <= '0;
      r_cnt_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (r_step) begin
      // Close the window including the strobe cycle's own spikes.
      r_spike_cnt <= w_next;
      r_ovf       <= r_ovf_acc | w_over;
      r_cnt_valid <= 1'b1;
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
    end else begin
      r_acc       <= w_next;
      r_ovf_acc   <= r_ovf_acc | w_over;
      r_cnt_valid <= 1'b0;
    end
  end

  assign bus.o_spike_cnt = r_spike_cnt;
  assign bus.o_cnt_valid = r_cnt_valid;
  assign bus.o_ovf       = r_ovf;

endmodule : spike_cnt_binner
`default_nettype wire
